apb_master_bridge: RTL and testbench

- Upstream neighbour of the APB slave block; the APB master that drives the shared APB bus signals.
- Converts a simple valid/ready command port from the local controller or testbench driver into a compliant APB4 transfer (IDLE -> SETUP -> ACCESS).
- Returns the read data and error status on a held response port.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master_bridge.sv | 144 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB constants and the master bridge state encoding.
package apb_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int DATA_WIDTH  = 32;
   localparam int PSTRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: valid/ready command in, IDLE->SETUP->ACCESS transfer on
// the APB bus, held response out. One transfer in flight at a time.
// Optional macro APB_MASTER_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT_CYCLES
// and reports an error response when the slave never answers.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH     = apb_pkg::DATA_WIDTH,
   parameter int PSTRB_WIDTH    = apb_pkg::PSTRB_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   PRESETn,
   // command port
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic                   cmd_write,
   input  logic [DATA_WIDTH-1:0]  cmd_wdata,
   input  logic [PSTRB_WIDTH-1:0] cmd_strb,
   input  logic [2:0]             cmd_prot,
   // response port
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_rdata,
   output logic                   rsp_slverr,
   // APB master side
   output logic [ADDR_WIDTH-1:0]  PADDR,
   output logic [2:0]             PPROT,
   output logic                   PSELx,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [DATA_WIDTH-1:0]  PWDATA,
   output logic [PSTRB_WIDTH-1:0] PSTRB,
   input  logic                   PREADY,
   input  logic [DATA_WIDTH-1:0]  PRDATA,
   input  logic                   PSLVERR
);

   import apb_pkg::*;

   apb_state_e r_state;
   apb_state_e w_state_nxt;

   logic w_accept;   // command handshake this cycle
   logic w_done;     // slave completes the ACCESS phase this cycle
   logic w_abort;    // wait limit hit with no PREADY (timeout build only)

   assign cmd_ready = (r_state == IDLE) && PRESETn;
   assign w_accept  = cmd_valid && cmd_ready;
   // PSLVERR/PRDATA only count on a genuine completing ACCESS cycle
   assign w_done    = PSELx && PENABLE && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
   logic [7:0] r_wait_cnt;

   // Count ACCESS cycles the slave has stalled; restart for every transfer
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         r_wait_cnt <= '0;
      end else if (r_state == SETUP) begin
         r_wait_cnt <= '0;
      end else if ((r_state == ACCESS) && !PREADY) begin
         r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   // This stalled cycle is the TIMEOUT_CYCLES-th one; PREADY on it still wins
   assign w_abort = (r_state == ACCESS) && !PREADY &&
                    (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign w_abort = 1'b0;
`endif

   // State register; reset aborts any transfer in flight
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)          w_state_nxt = SETUP;
         SETUP:                          w_state_nxt = ACCESS;
         ACCESS:  if (w_done || w_abort) w_state_nxt = RESP;
         RESP:    if (rsp_ready)         w_state_nxt = IDLE;
         default:                        w_state_nxt = IDLE;
      endcase
   end

   // Capture the command onto the bus; held until the next accept
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR  <= '0;
         PPROT  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
         PSTRB  <= '0;
      end else if (w_accept) begin
         PADDR  <= cmd_addr;
         PPROT  <= cmd_prot;
         PWRITE <= cmd_write;
         PWDATA <= cmd_wdata;
         PSTRB  <= cmd_write ? cmd_strb : '0;
      end
   end

   // PSELx/PENABLE: select from accept to completion, enable from ACCESS on
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         PSELx   <= 1'b0;
         PENABLE <= 1'b0;
      end else if (w_done || w_abort) begin
         PSELx   <= 1'b0;
         PENABLE <= 1'b0;
      end else if (w_accept) begin
         PSELx   <= 1'b1;
      end else if (r_state == SETUP) begin
         PENABLE <= 1'b1;
      end
   end

   // Response register: loaded at completion, held through RESP
   always_ff @(posedge clk or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else if (w_done) begin
         rsp_valid  <= 1'b1;
         rsp_rdata  <= PWRITE ? '0 : PRDATA;
         rsp_slverr <= PSLVERR;
      end else if (w_abort) begin
         rsp_valid  <= 1'b1;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b1;
      end else if ((r_state == RESP) && rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed + randomized bench for apb_master_bridge. The bench plays the APB
// slave cycle by cycle and predicts every bus/response value from the
// transfer rules (phase timing, strobe masking, read-data/error return).
module tb_apb_master_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic          clk;
   logic          PRESETn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic          cmd_write;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic [AW-1:0] PADDR;
   logic [2:0]    PPROT;
   logic          PSELx;
   logic          PENABLE;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic [SW-1:0] PSTRB;
   logic          PREADY;
   logic [DW-1:0] PRDATA;
   logic          PSLVERR;

   int checks   = 0;
   int failures = 0;

   apb_master_bridge #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PSTRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_slverr(rsp_slverr),
      .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transfer starting on a negedge with the bridge idle.
   // keepv leaves cmd_valid asserted afterwards so the next call is back-to-back.
   task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input int waits,
                       input logic [31:0] rd, input bit err, input int hold,
                       input bit keepv);
      logic [127:0] exp_bus;
      logic [31:0]  exp_rd;
      exp_bus = {56'd0, addr, wr, wd, (wr ? st : 4'h0), pr};
      exp_rd  = wr ? 32'd0 : rd;
      cmd_addr = addr; cmd_write = wr; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
      cmd_valid = 1'b1; rsp_ready = 1'b0;
      PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      #1;
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_psel", PSELx, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      // scramble the command port: the bus must not follow it
      cmd_valid = keepv;
      cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
      cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
      chk("setup_psel", PSELx, 1);
      chk("setup_penable", PENABLE, 0);
      chk("setup_bus", {56'd0, PADDR, PWRITE, PWDATA, PSTRB, PPROT}, exp_bus);
      chk("setup_cmd_ready", cmd_ready, 0);
      @(negedge clk);
      for (int i = 0; i < waits; i++) begin
         chk("wait_psel", PSELx, 1);
         chk("wait_penable", PENABLE, 1);
         chk("wait_bus", {56'd0, PADDR, PWRITE, PWDATA, PSTRB, PPROT}, exp_bus);
         chk("wait_rsp_valid", rsp_valid, 0);
         PRDATA = $urandom; PSLVERR = 1'($urandom);
         @(negedge clk);
      end
      PREADY = 1'b1; PRDATA = rd; PSLVERR = err;
      chk("access_psel", PSELx, 1);
      chk("access_penable", PENABLE, 1);
      chk("access_bus", {56'd0, PADDR, PWRITE, PWDATA, PSTRB, PPROT}, exp_bus);
      @(negedge clk);
      PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      for (int i = 0; i <= hold; i++) begin
         chk("resp_valid", rsp_valid, 1);
         chk("resp_rdata", rsp_rdata, exp_rd);
         chk("resp_slverr", rsp_slverr, err);
         chk("resp_psel", {PSELx, PENABLE}, 2'b00);
         chk("resp_cmd_ready", cmd_ready, 0);
         if (i == hold) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_psel", PSELx, 0);
   endtask

   initial begin
      PRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
      cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
      PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
      repeat (2) @(negedge clk);
      // reset state
      chk("rst_bus", {56'd0, PADDR, PWRITE, PWDATA, PSTRB, PPROT}, 0);
      chk("rst_sel", {PSELx, PENABLE}, 0);
      chk("rst_rsp", {rsp_valid, rsp_slverr, rsp_rdata}, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      PRESETn = 1'b1;
      @(negedge clk);

      // zero-wait write
      xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'hFFFF0000, 1'b0, 0, 1'b0);
      // read with 3 wait states
      xfer(32'h20, 1'b0, 32'hCAFEF00D, 4'hA, 3'd5, 3, 32'h12345678, 1'b0, 0, 1'b0);
      // slave error, response held 4 cycles
      xfer(32'h30, 1'b1, 32'h0BADF00D, 4'h3, 3'd2, 1, 32'h0, 1'b1, 4, 1'b0);
      // back-to-back with cmd_valid held high
      xfer(32'h40, 1'b0, 32'h1, 4'h1, 3'd1, 0, 32'hA5A5A5A5, 1'b0, 0, 1'b1);
      xfer(32'h44, 1'b1, 32'h2, 4'h6, 3'd7, 2, 32'h0, 1'b0, 1, 1'b0);

      // reset during ACCESS: everything drops at once, no response afterwards
      cmd_addr = 32'h50; cmd_write = 1'b0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_penable", PENABLE, 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("async_rst_sel", {PSELx, PENABLE, rsp_valid}, 3'b000);
      @(negedge clk);
      PRESETn = 1'b1; PREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_idle", {cmd_ready, PSELx, rsp_valid}, 3'b100);
      end
      PREADY = 1'b0;

      // reset while a response is pending
      cmd_addr = 32'h60; cmd_write = 1'b1; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      PREADY = 1'b1;
      @(negedge clk);
      PREADY = 1'b0;
      chk("pre_rst_rsp_valid", rsp_valid, 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("async_rst_rsp_valid", rsp_valid, 0);
      @(negedge clk);
      PRESETn = 1'b1;
      @(negedge clk);

      // randomized transfers, some back-to-back
      for (int n = 0; n < 24; n++) begin
         xfer($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
              $urandom_range(0, 4), $urandom, 1'($urandom), $urandom_range(0, 3),
              (n != 23) && ($urandom_range(0, 1) == 1));
      end

`ifdef APB_MASTER_TIMEOUT_EN
      // slave never answers: abort after TO stalled ACCESS cycles
      cmd_addr = 32'h70; cmd_write = 1'b0; cmd_valid = 1'b1; PREADY = 1'b0;
      PRDATA = 32'hFFFFFFFF;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < TO; i++) begin
         chk("to_wait_penable", PENABLE, 1);
         @(negedge clk);
      end
      chk("to_rsp", {PSELx, PENABLE, rsp_valid, rsp_slverr, rsp_rdata}, {4'b0011, 32'd0});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      // PREADY on the limit cycle completes normally
      cmd_addr = 32'h74; cmd_write = 1'b0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < TO - 1; i++) @(negedge clk);
      PREADY = 1'b1; PRDATA = 32'h55AA55AA; PSLVERR = 1'b0;
      @(negedge clk);
      PREADY = 1'b0;
      chk("to_edge_rsp", {rsp_valid, rsp_slverr, rsp_rdata}, {2'b10, 32'h55AA55AA});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
